mp_add_seq: RTL
===============

Name: mp_add_seq

Overview:
- Multi-precision add sequencer built around one shared 16-bit carry-skip adder (csa16a), instantiated inside this block.
- Accepts two WORDS×16-bit operands over a valid/ready handshake and adds them one 16-bit word per cycle, LSW first, chaining the carry through a register.
- Returns the full sum and final carry over a second valid/ready handshake.
- Sits between an operand producer (e.g. a crypto or bignum datapath) and its consumer. Area is one 16-bit adder, not a WORDS×16-bit adder.

Parameters:
- WORDS, 4: number of 16-bit words per operand. Legal range 2..16. Operand width W = 16*WORDS.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry into word 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  W  registered result.
- cout  output  1  carry out of word WORDS-1.
- busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. Registers: a_q, b_q (W), sum_q (W), carry_q (1), idx (clog2(WORDS) bits).
- Outputs: in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state!=IDLE); sum = sum_q; cout = carry_q.
- Reset (async, any state, including mid-RUN or mid-DONE):
  - state=IDLE, idx=0, a_q=b_q=0, sum_q=0, carry_q=0.
  - Result: out_valid=0, busy=0, sum=0, cout=0, in_ready=1.
  - While rst is high, no handshake is taken. Any in-flight operation is discarded with no partial result.
- IDLE:
  - On in_valid & in_ready: capture a, b into a_q, b_q; set carry_q=cin, idx=0; go to RUN.
  - sum_q is not cleared on accept. It holds the previous result until overwritten word by word.
- RUN, each cycle:
  - adder inputs = a_q[16*idx +: 16], b_q[16*idx +: 16], carry_q.
  - sum_q[16*idx +: 16] <= adder Sum; carry_q <= adder Cout; idx <= idx+1.
  - If idx==WORDS-1: idx <= 0 and go to DONE.
- DONE:
  - Hold sum_q and carry_q stable.
  - On out_ready: go to IDLE. in_ready is 0 throughout DONE, so no same-cycle re-accept.
- After returning to IDLE, sum/cout keep the last result until the next operation overwrites them.
- Latency: accept at edge k → out_valid high after edge k+WORDS. With out_ready tied high, the next accept is at edge k+WORDS+2 (throughput one op per WORDS+2 cycles).
- Input a/b/cin changes after accept have no effect (operands are captured).
- in_valid during RUN or DONE is ignored. The producer must hold in_valid and its data until in_ready.
- Arithmetic is modulo 2^W. Overflow out of the top word appears only on cout.
- out_valid, once high, stays high until out_ready is sampled high (no retraction).

Optional Feature:
- Macro MP_ADD_SEQ_SUB_EN.
- Defined:
  - Adds port op_sub (input, 1), captured on accept.
  - If op_sub=1: b_q captures ~b and carry_q is initialised to 1 (cin ignored), giving a − b mod 2^W.
  - cout = 1 means no borrow (a ≥ b unsigned).
  - If op_sub=0: behaviour is identical to the undefined case.
- Undefined: no op_sub port; add only.

Test Plan (WORDS=4):
1. a=0xFFFF_FFFF_FFFF_FFFF, b=0x0000_0000_0000_0001, cin=0 → sum=0, cout=1; out_valid rises exactly 4 cycles after accept; exercises carry propagation across all words.
2. a=0x0001_0002_0003_0004, b=0x0010_0020_0030_0040, cin=1 → sum=0x0011_0022_0033_0045, cout=0.
3. Backpressure: out_ready held low 5 cycles after out_valid while in_valid=1 with new operands → out_valid stays 1, sum/cout stable, in_ready=0. Release out_ready → IDLE for one cycle, then new operands accepted and computed correctly.
4. Assert rst 2 cycles into RUN → out_valid=0, busy=0, sum=0, cout=0, in_ready=1 immediately. A following op (case 2) yields the correct result.
5. in_valid and out_ready held high, alternating cases 1 and 2 → accepts spaced exactly 6 cycles apart, results in order and correct.
6. MP_ADD_SEQ_SUB_EN defined:
   - op_sub=1, a=5, b=7 → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0.
   - op_sub=1, a=7, b=5 → sum=2, cout=1.

Source files
------------

// File: rtl/mp_add_seq.sv
// Multi-precision adder: WORDS x 16-bit operands summed one word per cycle through a shared carry-skip adder.
// Optional subtract mode (op_sub port) is enabled by defining MP_ADD_SEQ_SUB_EN.

module csa16a (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [4:0] c;
  logic       rc;

  // Four 4-bit ripple groups; a group whose bits all propagate passes its carry-in straight through.
  always_comb begin
    c    = '0;
    sum  = '0;
    rc   = 1'b0;
    c[0] = cin;
    for (int k = 0; k < 4; k++) begin
      rc = c[k];
      for (int i = 0; i < 4; i++) begin
        sum[4*k+i] = a[4*k+i] ^ b[4*k+i] ^ rc;
        rc         = (a[4*k+i] & b[4*k+i]) | (rc & (a[4*k+i] ^ b[4*k+i]));
      end
      c[k+1] = (&(a[4*k +: 4] ^ b[4*k +: 4])) ? c[k] : rc;
    end
    cout = c[4];
  end

endmodule

module mp_add_seq #(
  parameter  int WORDS = 4,
  localparam int W     = 16 * WORDS,
  localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
`ifdef MP_ADD_SEQ_SUB_EN
  input  logic         op_sub,
`endif
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, b_q, sum_q;
  logic           carry_q;
  logic [IW-1:0]  idx;
  logic [IW+3:0]  base;
  logic [15:0]    add_sum;
  logic           add_cout;
  logic           last;
  logic           accept;
  logic [W-1:0]   b_cap;
  logic           carry_cap;

  assign base     = {idx, 4'b0000};
  assign last     = (idx == IW'(WORDS - 1));
  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready;

`ifdef MP_ADD_SEQ_SUB_EN
  // Subtraction is a + ~b + 1, so the operand is inverted and the chain seeded with 1.
  assign b_cap     = op_sub ? ~b : b;
  assign carry_cap = op_sub ? 1'b1 : cin;
`else
  assign b_cap     = b;
  assign carry_cap = cin;
`endif

  csa16a u_add (
    .a    (a_q[base +: 16]),
    .b    (b_q[base +: 16]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last)     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // sum_q is deliberately not cleared on accept; it keeps the previous result until overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b_cap;
      carry_q <= carry_cap;
      idx     <= '0;
    end else if (state_q == RUN) begin
      sum_q[base +: 16] <= add_sum;
      carry_q           <= add_cout;
      idx               <= last ? '0 : idx + IW'(1);
    end
  end

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = carry_q;

endmodule
